// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: LSB-first shift-add multiply or MSB-first restoring divide.
module muldiv_step #(
  parameter int unsigned W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  output logic [2*W-1:0] acc_next,
  output logic           q_bit
);

  logic [W:0]   mul_sum;
  logic [W:0]   shifted;
  logic [W+1:0] diff;
  logic         unused_diff_msb;

  // Divide packs {remainder, dividend-shifting-into-quotient} into acc.
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    shifted  = acc[2*W-1:W-1];
    diff     = {1'b0, shifted} - {2'b00, opnd};
    q_bit    = 1'b0;
    acc_next = {mul_sum, acc[W-1:1]};
    if (is_div) begin
      q_bit    = ~diff[W+1];
      acc_next = {(q_bit ? diff[W-1:0] : shifted[W-1:0]), acc[W-2:0], q_bit};
    end
  end

  // A successful subtract leaves a remainder below the divisor, so this bit is always zero.
  assign unused_diff_msb = diff[W];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit that stalls the pipeline until its result is ready.
module muldiv_seq #(
  parameter int unsigned XLEN  = muldiv_pkg::XLEN,
  parameter int unsigned STEPS = XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs_i,
  input  logic [XLEN-1:0] rt_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  import muldiv_pkg::*;

  localparam int unsigned CNT_BITS = $clog2(STEPS);

  logic [1:0]          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [2*XLEN-1:0]   acc_step;
  logic [XLEN-1:0]     result_sel;
  logic                unused_q_bit;
  logic                accept;
  logic                last;

  muldiv_step #(
    .W (XLEN)
  ) u_step (
    .is_div   (op_q[1]),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_step),
    .q_bit    (unused_q_bit)
  );

  assign accept = (state_q == S_IDLE) && req_i && !flush_i;
  assign last   = (cnt_q == CNT_BITS'(STEPS - 1));

  always_comb begin
    result_sel = acc_step[XLEN-1:0];
    unique case (op_q)
      OP_MUL:   result_sel = acc_step[XLEN-1:0];
      OP_MULHU: result_sel = acc_step[2*XLEN-1:XLEN];
      OP_DIVU:  result_sel = acc_step[XLEN-1:0];
      OP_REMU:  result_sel = acc_step[2*XLEN-1:XLEN];
      default:  result_sel = acc_step[XLEN-1:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Multiply: multiplier sits in the low half, multiplicand is the adder operand.
          // Divide: dividend sits in the low half, divisor is the subtrahend.
          op_d    = op_i;
          opnd_d  = op_i[1] ? rt_i : rs_i;
          acc_d   = {{XLEN{1'b0}}, (op_i[1] ? rs_i : rt_i)};
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d = acc_step;
        if (last) begin
          result_d = result_sel;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign stall_o  = accept || (state_q == S_BUSY);
  assign busy_o   = (state_q == S_BUSY);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .op_i     (op),
    .rs_i     (rs),
    .rt_i     (rt),
    .flush_i  (flush),
    .stall_o  (stall),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in the acceptance cycle T; returns sampled in the DONE cycle.
  task automatic wait_done(input string tag, input logic [31:0] exp);
    int n;
    bit seen;
    n    = stall ? 1 : 0;
    seen = 1'b0;
    step();
    req = 1'b0;
    rs  = $urandom;
    rt  = $urandom;
    check({tag, "_busy_t1"}, {31'b0, busy}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (stall) n++;
      step();
    end
    check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    check({tag, "_stall_cycles"}, n, 32'd33);
    check({tag, "_result"}, result, exp);
    check({tag, "_no_stall_in_done"}, {31'b0, stall}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    req = 1'b1;
    op  = o;
    rs  = a;
    rt  = b;
    #1;
    check({tag, "_stall_t0"}, {31'b0, stall}, 32'd1);
    wait_done(tag, exp);
  endtask

  task automatic to_idle(input string tag);
    step();
    check({tag, "_idle_done"}, {31'b0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    bit seen_done;
    rst   = 1'b1;
    req   = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    rs    = '0;
    rt    = '0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_result", result, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42);
    to_idle("mul_7x6");
    run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    to_idle("mulhu_ff");
    run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    to_idle("mul_ff");
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14);
    to_idle("divu_100_7");
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
    to_idle("remu_100_7");
    run_op("divu_by0", 2'b10, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    to_idle("divu_by0");
    run_op("remu_by0", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678);
    to_idle("remu_by0");

    // Back-to-back: second request already waiting while the first is in DONE.
    run_op("b2b_mul", 2'b00, 32'd3, 32'd5, 32'd15);
    req = 1'b1;
    op  = 2'b10;
    rs  = 32'd20;
    rt  = 32'd4;
    #1;
    check("b2b_done_ignores_req", {31'b0, stall}, 32'd0);
    step();
    check("b2b_gap_busy", {31'b0, busy}, 32'd0);
    check("b2b_gap_done", {31'b0, done}, 32'd0);
    check("b2b_gap_stall", {31'b0, stall}, 32'd1);
    wait_done("b2b_div", 32'd5);
    to_idle("b2b_div");

    // Flush at BUSY cycle 10.
    req = 1'b1;
    op  = 2'b00;
    rs  = 32'd9;
    rt  = 32'd9;
    step();
    req = 1'b0;
    repeat (9) step();
    check("flush_busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy_after", {31'b0, busy}, 32'd0);
    check("flush_stall_after", {31'b0, stall}, 32'd0);
    check("flush_done_after", {31'b0, done}, 32'd0);
    check("flush_result_kept", result, 32'd5);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1'b1;
      step();
    end
    check("flush_no_done", {31'b0, seen_done}, 32'd0);

    // Flush together with a request in IDLE.
    req   = 1'b1;
    flush = 1'b1;
    op    = 2'b00;
    rs    = 32'd1;
    rt    = 32'd1;
    #1;
    check("flush_req_stall", {31'b0, stall}, 32'd0);
    step();
    req   = 1'b0;
    flush = 1'b0;
    check("flush_req_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-BUSY.
    req = 1'b1;
    op  = 2'b00;
    rs  = 32'd1000;
    rt  = 32'd1000;
    step();
    req = 1'b0;
    repeat (5) step();
    check("rst_mid_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check("rst_mid_stall", {31'b0, stall}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    #1;
    rst = 1'b0;
    step();
    check("rst_after_busy", {31'b0, busy}, 32'd0);
    run_op("mul_2x2", 2'b00, 32'd2, 32'd2, 32'd4);
    to_idle("mul_2x2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
